// File: rtl/cdma_top.sv
// ---------------------------------------------------------------------------
// cdma_top -- four-user synchronous CDMA link core (spreader, shared channel
// adder, despreader) used as the link engine of the low-power CDMA router.
//
// Each user's DATA_W-bit word is latched once per frame of 4*DATA_W clocks.
// The word is spread MSB-first with a length-4 Walsh code. The four chip
// streams are summed into one signed channel sample per clock. Each user's
// bits are recovered by correlating the channel against that user's code.
// Recovered words appear DATA_W*4+1 clocks after the inputs were sampled.
//
// Ports:
//   clk                  system clock, rising edge
//   rst                  asynchronous, active-low reset
//   user1..4_data [DW]   words to transmit, sampled on the frame boundary
//   user1..4_out  [DW]   recovered words, all updated in the same cycle
//
// Optional build macro CDMA_DEBUG_EN adds:
//   chan_dbg   [4] signed  current channel register
//   frame_done [1]         one-cycle pulse in the clock after outputs update
//
// DATA_W must be at least 2.
// ---------------------------------------------------------------------------
module cdma_top #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] user1_data,
  input  logic [DATA_W-1:0] user2_data,
  input  logic [DATA_W-1:0] user3_data,
  input  logic [DATA_W-1:0] user4_data,
  output logic [DATA_W-1:0] user1_out,
  output logic [DATA_W-1:0] user2_out,
  output logic [DATA_W-1:0] user3_out,
  output logic [DATA_W-1:0] user4_out
`ifdef CDMA_DEBUG_EN
  ,
  output logic signed [3:0] chan_dbg,
  output logic              frame_done
`endif
);

  localparam int              FRAME = 4 * DATA_W;
  localparam int              CW    = $clog2(FRAME);
  localparam logic [CW-1:0]   LAST  = CW'(FRAME - 1);
  localparam logic [DATA_W-1:0] MSB = DATA_W'(1) << (DATA_W - 1);

  // Walsh chip sign: 1 means -1. Rows u1..u4 are the Hadamard rows, so the
  // sign of chip c for user index u is the parity of (u & c).
  function automatic logic walsh_neg(input logic [1:0] u, input logic [1:0] c);
    return ^(u & c);
  endfunction

  logic [DATA_W-1:0]  in_w   [4];
  logic [CW-1:0]      cnt_q,  cnt_d;
  logic [CW-1:0]      tag_q,  tag_d;   // cnt value that produced chan_q
  logic [DATA_W-1:0]  tx_q   [4];
  logic [DATA_W-1:0]  tx_d   [4];
  logic signed [3:0]  chan_q, chan_d;
  logic signed [5:0]  acc_q  [4];
  logic signed [5:0]  acc_d  [4];
  logic [DATA_W-1:0]  rx_q   [4];
  logic [DATA_W-1:0]  rx_d   [4];
  logic [DATA_W-1:0]  out_q  [4];
  logic [DATA_W-1:0]  out_d  [4];

  assign in_w[0] = user1_data;
  assign in_w[1] = user2_data;
  assign in_w[2] = user3_data;
  assign in_w[3] = user4_data;

  always_comb begin
    logic [1:0]        chip;
    logic [1:0]        tchip;
    logic [CW-1:0]     grp;
    logic              tx_bit;
    logic signed [5:0] p;
    logic signed [5:0] corr;
    logic              dec;

    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    tag_d  = cnt_q;
    chip   = cnt_q[1:0];
    grp    = cnt_q >> 2;
    tchip  = tag_q[1:0];
    chan_d = '0;
    tx_bit = 1'b0;
    p      = '0;
    corr   = '0;
    dec    = 1'b0;

    for (int u = 0; u < 4; u++) begin
      // Frame latch: inputs only matter on the last chip of a frame.
      tx_d[u] = (cnt_q == LAST) ? in_w[u] : tx_q[u];

      // Spreader + channel adder. Chip is +1 when data sign and code sign
      // agree, i.e. when (bit XOR code_negative) is 1.
      tx_bit = |(tx_q[u] & (MSB >> grp));
      if (tx_bit ^ walsh_neg(2'(u), chip))
        chan_d = chan_d + 4'sd1;
      else
        chan_d = chan_d - 4'sd1;

      // Despreader: correlate against own code over 4 chips.
      p = {{2{chan_q[3]}}, chan_q};
      if (walsh_neg(2'(u), tchip))
        p = -p;
      corr     = (tchip == 2'd0) ? p : acc_q[u] + p;
      acc_d[u] = corr;
      dec      = (corr > 6'sd0);

      rx_d[u] = rx_q[u];
      if (tchip == 2'd3)
        rx_d[u] = (rx_q[u] << 1) | DATA_W'(dec);

      // Publish the full word, including the bit decided this cycle.
      out_d[u] = (tag_q == LAST) ? rx_d[u] : out_q[u];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      tag_q  <= '0;
      chan_q <= '0;
      for (int u = 0; u < 4; u++) begin
        tx_q[u]  <= '0;
        acc_q[u] <= '0;
        rx_q[u]  <= '0;
        out_q[u] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      tag_q  <= tag_d;
      chan_q <= chan_d;
      for (int u = 0; u < 4; u++) begin
        tx_q[u]  <= tx_d[u];
        acc_q[u] <= acc_d[u];
        rx_q[u]  <= rx_d[u];
        out_q[u] <= out_d[u];
      end
    end
  end

  assign user1_out = out_q[0];
  assign user2_out = out_q[1];
  assign user3_out = out_q[2];
  assign user4_out = out_q[3];

`ifdef CDMA_DEBUG_EN
  logic frame_done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      frame_done_q <= 1'b0;
    else
      frame_done_q <= (tag_q == LAST);
  end

  assign chan_dbg   = chan_q;
  assign frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_cdma_top.sv
module tb_cdma_top;

  localparam int DATA_W = 4;
  localparam int FRAME  = 4 * DATA_W;
  localparam int LAT    = FRAME + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  user1_data, user2_data, user3_data, user4_data;
  logic [3:0]  user1_out, user2_out, user3_out, user4_out;
  logic [15:0] out_word;

  cdma_top #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .user1_data (user1_data),
    .user2_data (user2_data),
    .user3_data (user3_data),
    .user4_data (user4_data),
    .user1_out  (user1_out),
    .user2_out  (user2_out),
    .user3_out  (user3_out),
    .user4_out  (user4_out)
  );

  always #5 clk = ~clk;

  assign out_word = {user1_out, user2_out, user3_out, user4_out};

  int          n_chk = 0;
  int          n_err = 0;
  int          k     = 0;        // rising edges since reset release
  logic [15:0] cur_in;
  logic [15:0] hist [0:8191];    // input word present at each edge
  int          chan_tab [4];
  bit          chan_en = 1'b0;

  task automatic check_val(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s edge=%0d observed=%0h required=%0h", tag, k, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] w);
    cur_in     = w;
    user1_data = w[15:12];
    user2_data = w[11:8];
    user3_data = w[7:4];
    user4_data = w[3:0];
  endtask

  // Reference: outputs change only on edges 17, 33, 49, ...; the word shown
  // from edge j on is whatever was on the inputs at edge j-17, except that
  // edge 17 shows the all-zero frame transmitted before the first sample.
  function automatic int exp_word(input int edge_n);
    int j;
    if (edge_n < LAT) return 0;
    j = edge_n - ((edge_n - LAT) % FRAME);
    if (j - LAT == 0) return 0;
    return int'(hist[j - LAT]);
  endfunction

  task automatic tick(input logic [15:0] nxt);
    @(posedge clk);
    k++;
    hist[k] = cur_in;
    @(negedge clk);
    check_val("out", int'(out_word), exp_word(k));
    if (chan_en && k >= 17 && k <= 20)
      check_val("chan", int'(dut.chan_q), chan_tab[k - 17]);
    drive(nxt);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check_val("rst_async", int'(out_word), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    k   = 0;
  endtask

  initial begin
    logic [15:0] pa, pb, nxt;
    pa = {4'b1010, 4'b1100, 4'b0110, 4'b1001};
    pb = {4'b1111, 4'b0000, 4'b1011, 4'b0101};

    // Power-on reset with pattern A already applied.
    drive(pa);
    repeat (3) @(negedge clk);
    check_val("rst_init", int'(out_word), 0);
    rst = 1'b1;
    k   = 0;

    // Pattern A: zeros through edge 32, A from edge 33, chan +2,-2,+2,+2.
    chan_tab = '{2, -2, 2, 2};
    chan_en  = 1'b1;
    for (int i = 0; i < 48; i++) tick(pa);
    chan_en = 1'b0;

    // Switch to pattern B after frame 1.
    for (int i = 0; i < 48; i++) tick(pb);

    // Transient change inside a frame (cnt 5..12) must never be sampled.
    for (int i = 0; i < 48; i++) begin
      nxt = (((k + 1) % FRAME) >= 6 && ((k + 1) % FRAME) <= 13) ? 16'h5A5A : pb;
      tick(nxt);
    end

    // Mid-run asynchronous reset, then all users 1111.
    do_reset();
    drive(16'hFFFF);
    chan_tab = '{4, 0, 0, 0};
    chan_en  = 1'b1;
    for (int i = 0; i < 48; i++) tick(16'hFFFF);
    chan_en = 1'b0;

    // Reset in the middle of a frame, then all users 0000.
    for (int i = 0; i < 7; i++) tick(16'hFFFF);
    do_reset();
    drive(16'h0000);
    chan_tab = '{-4, 0, 0, 0};
    chan_en  = 1'b1;
    for (int i = 0; i < 48; i++) tick(16'h0000);
    chan_en = 1'b0;

    // Random: new words every clock, 200 frames plus pipeline flush.
    do_reset();
    drive(16'($urandom));
    for (int i = 0; i < 200 * FRAME + 2 * LAT; i++) tick(16'($urandom));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
